reverse_loop_sequencer: RTL and testbench
=========================================

# reverse_loop_sequencer

- Two-level loop sequencer: counts down instead of up.
  - Accepts an outer and inner trip count on a start pulse.
  - Emits every (outer, inner) index pair from (OuterCount-1, InnerCount-1) down to (0, 0) over a valid/ready stream.
  - Signals completion with a one-cycle done pulse.
- Sits beside the wrap-around up-counters in the accelerator datapath.
  - Drives reverse-order tile/row traversal, e.g. reading buffers back in the opposite order to the order in which they were written.
  - Provides per-beat last-inner/last-outer flags for downstream accumulate/flush control.

## Interface
- COUNTER_WIDTH, default 8, width of trip counts and index outputs.
- CLK  input  1  clock, all state updates on rising edge.
- ASYNC_RST  input  1  asynchronous active-high reset.
- START  input  1  begin a sequence; honoured only in IDLE.
- ABORT  input  1  synchronous abort; returns to IDLE without Done.
- OuterCount  input  COUNTER_WIDTH  outer trip count, sampled only on an accepted START.
- InnerCount  input  COUNTER_WIDTH  inner trip count, sampled only on an accepted START.
- OutReady  input  1  downstream ready.
- OutValid  output  1  index pair valid.
- OuterIdx  output  COUNTER_WIDTH  current outer index.
- InnerIdx  output  COUNTER_WIDTH  current inner index.
- LastInner  output  1  OutValid && InnerIdx==0.
- LastOuter  output  1  OutValid && OuterIdx==0.
- Busy  output  1  high in RUN.
- Done  output  1  one-cycle completion pulse.

## Operation
- States: IDLE, RUN.
- Reset (ASYNC_RST high, any time):
  - State goes to IDLE.
  - OutValid, Busy, Done, OuterIdx, InnerIdx, LastInner and LastOuter all go to 0.
  - Latched counts go to 0.
- IDLE, START=1, both counts nonzero:
  - Latch InnerCount as the inner reload value.
  - Load OuterIdx=OuterCount-1 and InnerIdx=InnerCount-1.
  - Go to RUN.
- IDLE, START=1, either count zero:
  - Stay in IDLE, emit no beats.
  - Done pulses the next cycle.
- RUN:
  - OutValid=1.
  - A beat transfers when OutValid && OutReady.
  - On a transfer with InnerIdx>0: InnerIdx decrements.
  - On a transfer with InnerIdx==0 and OuterIdx>0: InnerIdx reloads to latched InnerCount-1 and OuterIdx decrements.
  - On a transfer with both indices 0: go to IDLE, Done=1 for the next cycle, OutValid=0.
- Stall: while OutValid && !OutReady, OuterIdx, InnerIdx, LastInner and LastOuter hold stable.
- Input changes during RUN: OuterCount and InnerCount are ignored. START is ignored.
- ABORT:
  - Has highest priority after reset, above START and above a transfer in the same cycle.
  - Next cycle: IDLE, OutValid=0, Busy=0, Done=0.
  - Indices clear to 0.
- Width rules:
  - Index arithmetic is unsigned COUNTER_WIDTH.
  - Indices never wrap below 0.
  - Maximum count 2^COUNTER_WIDTH-1.
  - Total beats = OuterCount*InnerCount; no internal product is formed.
- Indices in IDLE read 0.

## Timing
- START accepted at edge t → OutValid=1, Busy=1 with the first pair from edge t+1.
- Throughput: with OutReady held high, one beat per cycle. The sequence occupies exactly OuterCount*InnerCount RUN cycles.
- Final transfer at edge t → Done=1 and Busy=0 during cycle t..t+1. Done is high for exactly one cycle.
- Zero-count START at edge t → Done=1 for one cycle after t. Busy stays 0.
- START asserted during the Done cycle is accepted (state is IDLE). This gives back-to-back sequences with one idle cycle between final beat and next first beat.
- LastInner and LastOuter are combinational from registered state, qualified by OutValid. They carry no extra latency.
- ASYNC_RST deassertion takes no effect until the next rising edge. START coincident with that edge is honoured.

## Test plan
- Basic order: Outer=2, Inner=3, OutReady=1.
  - Required beats: (1,2),(1,1),(1,0),(0,2),(0,1),(0,0).
  - LastInner on beats 3 and 6; LastOuter on beats 4-6.
  - Done exactly one cycle after beat 6.
- Backpressure: Outer=1, Inner=4, OutReady toggling 1,0,0,1,...
  - Indices hold while stalled.
  - Exactly 4 transfers: 3,2,1,0.
  - Done after last transfer.
  - No duplicate or skipped index.
- Zero count: START with Outer=0, Inner=5.
  - No OutValid.
  - Busy stays 0.
  - Done one cycle later.
- Abort mid-run: Outer=3, Inner=3, ABORT on the cycle of transfer (2,0).
  - Next cycle OutValid=0, Busy=0, indices 0.
  - Done never pulses.
  - New START then restarts at (2,2).
- Input isolation and back-to-back: change OuterCount/InnerCount and pulse START during RUN.
  - Sequence unaffected.
  - START during the Done cycle with Outer=1, Inner=1 produces beat (0,0) next cycle, then a second Done.
- Reset mid-run: assert ASYNC_RST asynchronously between edges during RUN.
  - All outputs 0 immediately.
  - State IDLE after release.
  - Width check with COUNTER_WIDTH=4, Outer=Inner=15: first beat (14,14), 225 beats total.

Source files
------------

// File: rtl/reverse_loop_sequencer_if.sv
// Stream and control bundle for the reverse (count-down) two-level loop sequencer.
// The sequencer connects through the slave modport. The driving side connects through the master modport.
interface reverse_loop_sequencer_if #(
  parameter int COUNTER_WIDTH = 8
);
  logic                     START;
  logic                     ABORT;
  logic [COUNTER_WIDTH-1:0] OuterCount;
  logic [COUNTER_WIDTH-1:0] InnerCount;
  logic                     OutReady;
  logic                     OutValid;
  logic [COUNTER_WIDTH-1:0] OuterIdx;
  logic [COUNTER_WIDTH-1:0] InnerIdx;
  logic                     LastInner;
  logic                     LastOuter;
  logic                     Busy;
  logic                     Done;

  modport master (
    output START, ABORT, OuterCount, InnerCount, OutReady,
    input  OutValid, OuterIdx, InnerIdx, LastInner, LastOuter, Busy, Done
  );

  modport slave (
    input  START, ABORT, OuterCount, InnerCount, OutReady,
    output OutValid, OuterIdx, InnerIdx, LastInner, LastOuter, Busy, Done
  );
endinterface

// File: rtl/reverse_loop_sequencer.sv
// Two-level count-down loop sequencer. It emits (outer, inner) index pairs from
// (OuterCount-1, InnerCount-1) down to (0,0) over valid/ready, followed by a one-cycle Done.
module reverse_loop_sequencer #(
  parameter int COUNTER_WIDTH = 8
) (
  input  logic                    CLK,
  input  logic                    ASYNC_RST,
  reverse_loop_sequencer_if.slave seq
);
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [COUNTER_WIDTH-1:0] IDX_ZERO = {COUNTER_WIDTH{1'b0}};
  localparam logic [COUNTER_WIDTH-1:0] IDX_ONE  = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

  state_t                   state_r, state_s;
  logic [COUNTER_WIDTH-1:0] outer_idx_r, outer_idx_s;
  logic [COUNTER_WIDTH-1:0] inner_idx_r, inner_idx_s;
  logic [COUNTER_WIDTH-1:0] inner_reload_r, inner_reload_s;
  logic                     done_r, done_s;
  logic                     valid_s;

  // State, index and completion registers
  always_ff @(posedge CLK or posedge ASYNC_RST) begin
    if (ASYNC_RST) begin
      state_r        <= ST_IDLE;
      outer_idx_r    <= IDX_ZERO;
      inner_idx_r    <= IDX_ZERO;
      inner_reload_r <= IDX_ZERO;
      done_r         <= 1'b0;
    end else begin
      state_r        <= state_s;
      outer_idx_r    <= outer_idx_s;
      inner_idx_r    <= inner_idx_s;
      inner_reload_r <= inner_reload_s;
      done_r         <= done_s;
    end
  end

  // Next-state logic: abort overrides both start and transfer.
  always_comb begin
    state_s        = state_r;
    outer_idx_s    = outer_idx_r;
    inner_idx_s    = inner_idx_r;
    inner_reload_s = inner_reload_r;
    done_s         = 1'b0;
    if (seq.ABORT) begin
      state_s     = ST_IDLE;
      outer_idx_s = IDX_ZERO;
      inner_idx_s = IDX_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (seq.START) begin
            if ((seq.OuterCount != IDX_ZERO) && (seq.InnerCount != IDX_ZERO)) begin
              inner_reload_s = seq.InnerCount;
              outer_idx_s    = seq.OuterCount - IDX_ONE;
              inner_idx_s    = seq.InnerCount - IDX_ONE;
              state_s        = ST_RUN;
            end else begin
              done_s = 1'b1;
            end
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (seq.OutReady) begin
            if (inner_idx_r != IDX_ZERO) begin
              inner_idx_s = inner_idx_r - IDX_ONE;
            end else if (outer_idx_r != IDX_ZERO) begin
              inner_idx_s = inner_reload_r - IDX_ONE;
              outer_idx_s = outer_idx_r - IDX_ONE;
            end else begin
              // Both indices are already zero, so IDLE reads 0 without an explicit clear.
              state_s = ST_IDLE;
              done_s  = 1'b1;
            end
          end else begin
            state_s = ST_RUN;
          end
        end
        default: begin
          state_s     = ST_IDLE;
          outer_idx_s = IDX_ZERO;
          inner_idx_s = IDX_ZERO;
        end
      endcase
    end
  end

  assign valid_s       = (state_r == ST_RUN);
  assign seq.OutValid  = valid_s;
  assign seq.Busy      = valid_s;
  assign seq.Done      = done_r;
  assign seq.OuterIdx  = outer_idx_r;
  assign seq.InnerIdx  = inner_idx_r;
  assign seq.LastInner = valid_s && (inner_idx_r == IDX_ZERO);
  assign seq.LastOuter = valid_s && (outer_idx_r == IDX_ZERO);
endmodule

// File: tb/tb_reverse_loop_sequencer.sv
// Self-checking bench: a queue-based model of the expected beat stream, directed scenarios and random traffic.
module tb_reverse_loop_sequencer;
  logic CLK = 1'b0;
  logic ASYNC_RST = 1'b1;
  always #5 CLK = ~CLK;

  reverse_loop_sequencer_if #(.COUNTER_WIDTH(8)) bus ();
  reverse_loop_sequencer_if #(.COUNTER_WIDTH(4)) bus4 ();

  reverse_loop_sequencer #(.COUNTER_WIDTH(8)) dut (.CLK(CLK), .ASYNC_RST(ASYNC_RST), .seq(bus.slave));
  reverse_loop_sequencer #(.COUNTER_WIDTH(4)) dut4 (.CLK(CLK), .ASYNC_RST(ASYNC_RST), .seq(bus4.slave));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: the queue holds the pairs still to be emitted. An empty queue means idle.
  logic [15:0] mq[$];
  bit          m_done = 1'b0;
  int          cyc = 0;
  logic [17:0] beat_log[$];
  int          beat_cyc = 0;
  int          done_cyc = 0;
  int          done_cnt = 0;

  initial begin
    bit          ev;
    bit          nd;
    logic [15:0] front;
    int          oc;
    int          ic;
    forever begin
      @(negedge CLK);
      cyc++;
      if (ASYNC_RST) begin
        mq.delete();
        m_done = 1'b0;
      end
      ev    = (mq.size() != 0);
      front = ev ? mq[0] : 16'h0000;
      check("valid", bus.OutValid, ev);
      check("busy", bus.Busy, ev);
      check("done", bus.Done, m_done);
      check("outer_idx", bus.OuterIdx, front[15:8]);
      check("inner_idx", bus.InnerIdx, front[7:0]);
      check("last_inner", bus.LastInner, ev && (front[7:0] == 8'd0));
      check("last_outer", bus.LastOuter, ev && (front[15:8] == 8'd0));
      if (bus.OutValid && bus.OutReady) begin
        beat_log.push_back({bus.LastInner, bus.LastOuter, bus.OuterIdx, bus.InnerIdx});
        beat_cyc = cyc;
      end
      if (bus.Done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (!ASYNC_RST) begin
        nd = 1'b0;
        oc = int'(bus.OuterCount);
        ic = int'(bus.InnerCount);
        if (bus.ABORT) begin
          mq.delete();
        end else if (mq.size() == 0) begin
          if (bus.START) begin
            if (oc != 0 && ic != 0) begin
              for (int o = oc - 1; o >= 0; o--)
                for (int i = ic - 1; i >= 0; i--)
                  mq.push_back({8'(o), 8'(i)});
            end else begin
              nd = 1'b1;
            end
          end
        end else if (bus.OutReady) begin
          void'(mq.pop_front());
          if (mq.size() == 0) nd = 1'b1;
        end
        m_done = nd;
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_seq(input int oc, input int ic);
    bus.OuterCount = 8'(oc);
    bus.InnerCount = 8'(ic);
    bus.START      = 1'b1;
    step();
    bus.START = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0;
    d0 = done_cnt;
    for (int k = 0; k < budget; k++) begin
      if (done_cnt != d0) break;
      step();
    end
    check(name, done_cnt != d0, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [17:0] exp_basic [6];
    logic [15:0] exp_b2b [5];
    int d0;
    int nb;
    int beats4;
    bit got4;
    exp_basic = '{18'h00102, 18'h00101, 18'h20100, 18'h10002, 18'h10001, 18'h30000};
    exp_b2b   = '{16'h0101, 16'h0100, 16'h0001, 16'h0000, 16'h0000};

    bus.START = 1'b0; bus.ABORT = 1'b0; bus.OuterCount = 8'd0; bus.InnerCount = 8'd0; bus.OutReady = 1'b0;
    bus4.START = 1'b0; bus4.ABORT = 1'b0; bus4.OuterCount = 4'd0; bus4.InnerCount = 4'd0; bus4.OutReady = 1'b0;
    step(); step();
    check("reset_valid", bus.OutValid, 1'b0);
    check("reset_idx", {bus.OuterIdx, bus.InnerIdx}, 16'h0000);
    ASYNC_RST = 1'b0;
    step();

    // Basic order
    beat_log.delete();
    bus.OutReady = 1'b1;
    start_seq(2, 3);
    wait_done("basic_done", 20);
    check("basic_count", beat_log.size(), 6);
    for (int i = 0; i < 6; i++)
      check("basic_beat", (i < beat_log.size()) ? beat_log[i] : 18'h3ffff, exp_basic[i]);
    check("basic_done_lat", done_cyc, beat_cyc + 1);

    // Backpressure
    beat_log.delete();
    d0 = done_cnt;
    bus.OuterCount = 8'd1; bus.InnerCount = 8'd4;
    for (int k = 0; k < 40; k++) begin
      bus.OutReady = (k % 3 == 0);
      bus.START    = (k == 0);
      step();
      if (done_cnt != d0) break;
    end
    bus.START = 1'b0;
    check("bp_done", done_cnt, d0 + 1);
    check("bp_count", beat_log.size(), 4);
    for (int i = 0; i < 4; i++)
      check("bp_beat", (i < beat_log.size()) ? beat_log[i][15:0] : 16'hffff, 16'(3 - i));

    // Zero count
    bus.OutReady = 1'b1;
    d0 = done_cnt;
    nb = beat_log.size();
    start_seq(0, 5);
    check("zero_done_now", bus.Done, 1'b1);
    check("zero_busy", bus.Busy, 1'b0);
    step(); step();
    check("zero_done_cnt", done_cnt, d0 + 1);
    check("zero_no_beats", beat_log.size(), nb);

    // Abort on the (2,0) transfer
    d0 = done_cnt;
    start_seq(3, 3);
    step(); step();
    check("abort_at_pair", {bus.OuterIdx, bus.InnerIdx}, 16'h0200);
    bus.ABORT = 1'b1;
    step();
    bus.ABORT = 1'b0;
    check("abort_outs", {bus.OutValid, bus.Busy, bus.Done, bus.OuterIdx, bus.InnerIdx}, 19'h0);
    step(); step();
    check("abort_no_done", done_cnt, d0);
    beat_log.delete();
    start_seq(3, 3);
    check("restart_first", {bus.OutValid, bus.OuterIdx, bus.InnerIdx}, 17'h10202);
    wait_done("restart_done", 20);
    check("restart_count", beat_log.size(), 9);

    // Input isolation and back-to-back start
    beat_log.delete();
    d0 = done_cnt;
    start_seq(2, 2);
    bus.START = 1'b1; bus.OuterCount = 8'd7; bus.InnerCount = 8'd9;
    step();
    bus.OuterCount = 8'd5;
    step(); step();
    bus.START = 1'b0;
    step();
    check("b2b_done1", bus.Done, 1'b1);
    start_seq(1, 1);
    check("b2b_beat", {bus.OutValid, bus.OuterIdx, bus.InnerIdx}, 17'h10000);
    step();
    check("b2b_done2", bus.Done, 1'b1);
    step();
    check("b2b_done_cnt", done_cnt, d0 + 2);
    check("b2b_count", beat_log.size(), 5);
    for (int i = 0; i < 5; i++)
      check("b2b_beat_seq", (i < beat_log.size()) ? beat_log[i][15:0] : 16'hffff, exp_b2b[i]);

    // Width check on the 4-bit instance
    bus4.OuterCount = 4'd15; bus4.InnerCount = 4'd15; bus4.OutReady = 1'b1; bus4.START = 1'b1;
    step();
    bus4.START = 1'b0;
    check("w4_first", {bus4.OutValid, bus4.OuterIdx, bus4.InnerIdx}, 9'h1ee);
    beats4 = 0;
    got4 = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (bus4.Done) begin
        got4 = 1'b1;
        break;
      end
      if (bus4.OutValid) beats4++;
      step();
    end
    check("w4_beats", beats4, 225);
    check("w4_done", got4, 1'b1);

    // Reset mid-run
    start_seq(4, 4);
    step();
    #1 ASYNC_RST = 1'b1;
    #1;
    check("rst_outs", {bus.OutValid, bus.Busy, bus.Done, bus.LastInner, bus.LastOuter, bus.OuterIdx, bus.InnerIdx}, 21'h0);
    @(posedge CLK);
    #1 ASYNC_RST = 1'b0;
    check("rst_idle", bus.Busy, 1'b0);
    step();
    check("rst_idle2", bus.OutValid, 1'b0);
    start_seq(1, 2);
    check("rst_restart", {bus.OutValid, bus.OuterIdx, bus.InnerIdx}, 17'h10001);
    wait_done("rst_restart_done", 10);

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      bus.START      = ($urandom_range(0, 5) == 0);
      bus.OuterCount = 8'($urandom_range(0, 4));
      bus.InnerCount = 8'($urandom_range(0, 4));
      bus.OutReady   = ($urandom_range(0, 3) != 0);
      bus.ABORT      = ($urandom_range(0, 40) == 0);
      step();
    end
    bus.START = 1'b0; bus.ABORT = 1'b0; bus.OutReady = 1'b1;
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
